// File: rtl/ram_pkg.sv
// Shared definitions for the simple-dual-port RAM block: control FSM
// encoding and the legal range of the read pipeline depth.
package ram_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } ram_state_e;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 4;

   function automatic bit rd_lat_legal(input int lat);
      return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
   endfunction

endpackage

// File: rtl/ram_read_pipe.sv
// Data+valid delay line placed after the RAM read register. Each stage only
// captures data when the valid entering it is set, so the last stage holds
// the most recent response while no new one arrives. STAGES=0 is a bypass.
module ram_read_pipe #(
   parameter int WIDTH  = 64,
   parameter int STAGES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_vld,
   output logic [WIDTH-1:0] out_data
);

   generate
      if (STAGES == 0) begin : g_bypass
         assign out_vld  = in_vld;
         assign out_data = in_data;
      end else begin : g_pipe
         logic [STAGES-1:0] vld_q;
         logic [STAGES-1:0] vld_d;
         logic [WIDTH-1:0]  data_q [STAGES];
         logic [WIDTH-1:0]  data_d [STAGES];
         logic [STAGES:0]   tap_vld;
         logic [WIDTH-1:0]  tap_data [STAGES+1];

         assign tap_vld     = {vld_q, in_vld};
         assign tap_data[0] = in_data;
         for (genvar s = 0; s < STAGES; s++) begin : g_tap
            assign tap_data[s+1] = data_q[s];
         end

         // Shift valid every cycle; advance data only alongside a valid.
         always_comb begin
            vld_d = '0;
            for (int s = 0; s < STAGES; s++) begin
               vld_d[s]  = tap_vld[s];
               data_d[s] = tap_vld[s] ? tap_data[s] : data_q[s];
            end
         end

         // Stage registers; reset flushes in-flight responses and zeroes data.
         always_ff @(posedge clk) begin
            if (rst) begin
               vld_q <= '0;
               for (int s = 0; s < STAGES; s++) begin
                  data_q[s] <= '0;
               end
            end else begin
               vld_q  <= vld_d;
               data_q <= data_d;
            end
         end

         assign out_vld  = tap_vld[STAGES];
         assign out_data = tap_data[STAGES];
      end
   endgenerate

endmodule

// File: rtl/ram_block_sdp.sv
// Simple-dual-port block RAM with per-byte-lane write enables, configurable
// read latency, selectable same-address collision behaviour and an optional
// zero-fill sequence after reset.
module ram_block_sdp
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH     = 64,
   parameter int ADDR_WIDTH     = 10,
   parameter int BYTE_WIDTH     = 8,
   parameter int READ_LATENCY   = 2,
   parameter int WRITE_FIRST    = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             wr_en,
   input  logic [ADDR_WIDTH-1:0]            wr_addr,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
   input  logic [DATA_WIDTH-1:0]            wr_data,
   input  logic                             rd_en,
   input  logic [ADDR_WIDTH-1:0]            rd_addr,
   output logic [DATA_WIDTH-1:0]            rd_data,
   output logic                             rd_valid,
   output logic                             init_done
);

   localparam int NB          = DATA_WIDTH / BYTE_WIDTH;
   localparam int DEPTH       = 2 ** ADDR_WIDTH;
   localparam int PIPE_STAGES = READ_LATENCY - 1;

   generate
      if (!rd_lat_legal(READ_LATENCY)) begin : g_bad_latency
         $error("ram_block_sdp: READ_LATENCY must be within 1..4");
      end
      if ((DATA_WIDTH < BYTE_WIDTH) || ((DATA_WIDTH % BYTE_WIDTH) != 0)) begin : g_bad_lanes
         $error("ram_block_sdp: DATA_WIDTH must be a multiple of BYTE_WIDTH");
      end
   endgenerate

   ram_state_e              state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic                    init_done_q, init_done_d;

   // Next-state logic: reset parks the FSM in CLEAR with the counter at zero;
   // CLEAR walks every address once (or leaves at once when no fill is wanted).
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      init_done_d = init_done_q;
      if (rst) begin
         state_d     = ST_CLEAR;
         cnt_d       = '0;
         init_done_d = 1'b0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               if ((CLEAR_ON_RESET == 0) || (cnt_q == '1)) begin
                  state_d     = ST_READY;
                  cnt_d       = '0;
                  init_done_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_READY: begin
               init_done_d = 1'b1;
            end
            default: begin
               state_d     = ST_CLEAR;
               cnt_d       = '0;
               init_done_d = 1'b0;
            end
         endcase
      end
   end

   // Control FSM registers, including the registered init_done output.
   always_ff @(posedge clk) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
   end

   assign init_done = init_done_q;

   // Single physical write port shared by the zero-fill and the user port.
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [NB-1:0]         mem_be;
   logic [DATA_WIDTH-1:0] mem_wdata;

   // Select the write source; nothing reaches the array while rst is high.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = wr_addr;
      mem_be    = wr_be;
      mem_wdata = wr_data;
      if (!rst) begin
         if (state_q == ST_CLEAR) begin
            if (CLEAR_ON_RESET != 0) begin
               mem_we    = 1'b1;
               mem_addr  = cnt_q;
               mem_be    = '1;
               mem_wdata = '0;
            end
         end else begin
            mem_we = wr_en;
         end
      end
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Array write with one enable per byte lane (block RAM byte-write form).
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < NB; i++) begin
            if (mem_be[i]) begin
               mem[mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   logic                  rd_acc;
   logic                  rd_hit;
   logic [DATA_WIDTH-1:0] rd_old;
   logic [DATA_WIDTH-1:0] rd_merged;
   logic [DATA_WIDTH-1:0] rd_word_q, rd_word_d;
   logic                  rd_vld_q, rd_vld_d;

   assign rd_acc = rd_en && (state_q == ST_READY) && !rst;
   assign rd_hit = mem_we && (mem_addr == rd_addr);
   assign rd_old = mem[rd_addr];

   // Read word selection: a write-first collision returns the word as it
   // will look after this edge's lane update; otherwise the stored word.
   always_comb begin
      rd_merged = rd_old;
      for (int i = 0; i < NB; i++) begin
         if (mem_be[i]) begin
            rd_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
      rd_vld_d  = rd_acc;
      rd_word_d = rd_word_q;
      if (rd_acc) begin
         rd_word_d = ((WRITE_FIRST != 0) && rd_hit) ? rd_merged : rd_old;
      end
   end

   // RAM output register: first cycle of read latency, holds between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_vld_q  <= 1'b0;
         rd_word_q <= '0;
      end else begin
         rd_vld_q  <= rd_vld_d;
         rd_word_q <= rd_word_d;
      end
   end

   ram_read_pipe #(
      .WIDTH  (DATA_WIDTH),
      .STAGES (PIPE_STAGES)
   ) u_read_pipe (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (rd_vld_q),
      .in_data  (rd_word_q),
      .out_vld  (rd_valid),
      .out_data (rd_data)
   );

endmodule

// File: tb/tb_ram_block_sdp.sv
// Directed bench for ram_block_sdp. Two instances share stimulus:
// dut0 = read-first, latency 3; dut1 = write-first, latency 1.
module tb_ram_block_sdp;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [7:0]  wr_be;
   logic [63:0] wr_data;
   logic        rd_en;
   logic [3:0]  rd_addr;
   logic [63:0] rd_data0, rd_data1;
   logic        rd_valid0, rd_valid1;
   logic        init_done0, init_done1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ram_block_sdp #(
      .DATA_WIDTH(64), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
      .READ_LATENCY(3), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)
   ) dut0 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
      .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data0), .rd_valid(rd_valid0), .init_done(init_done0)
   );

   ram_block_sdp #(
      .DATA_WIDTH(64), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
      .READ_LATENCY(1), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)
   ) dut1 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
      .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data1), .rd_valid(rd_valid1), .init_done(init_done1)
   );

   typedef struct {
      logic        we;
      logic [3:0]  wa;
      logic [7:0]  be;
      logic [63:0] wd;
      logic        re;
      logic [3:0]  ra;
      logic [63:0] e0;
      logic [63:0] e1;
   } vec_t;

   vec_t vecs[11];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
      rd_en = 1'b0; rd_addr = '0;
   endtask

   // One request cycle, then watch both responses for four cycles.
   task automatic apply_vec(input vec_t v, input string name);
      logic [3:0]  p0, p1;
      logic [63:0] d0, d1, h0, h1;
      wr_en = v.we; wr_addr = v.wa; wr_be = v.be; wr_data = v.wd;
      rd_en = v.re; rd_addr = v.ra;
      tick();
      idle_inputs();
      p0 = '0; p1 = '0; d0 = '0; d1 = '0; h0 = '0; h1 = '0;
      for (int k = 1; k <= 4; k++) begin
         p0[k-1] = rd_valid0;
         p1[k-1] = rd_valid1;
         if (k == 1) d1 = rd_data1;
         if (k == 3) d0 = rd_data0;
         if (k == 4) begin
            h0 = rd_data0;
            h1 = rd_data1;
         end
         tick();
      end
      check({name, "_vld0"}, 64'(p0), v.re ? 64'h4 : 64'h0);
      check({name, "_vld1"}, 64'(p1), v.re ? 64'h1 : 64'h0);
      if (v.re) begin
         check({name, "_dat0"}, d0, v.e0);
         check({name, "_dat1"}, d1, v.e1);
         check({name, "_hold0"}, h0, v.e0);
         check({name, "_hold1"}, h1, v.e1);
      end
   endtask

   // Count cycles from now until each init_done rises (bounded).
   task automatic wait_ready(output int c0, output int c1, output logic anyv);
      c0 = -1; c1 = -1; anyv = 1'b0;
      for (int c = 1; c <= 40 && (c0 < 0 || c1 < 0); c++) begin
         tick();
         if (init_done0 && c0 < 0) c0 = c;
         if (init_done1 && c1 < 0) c1 = c;
         anyv = anyv | rd_valid0 | rd_valid1;
      end
   endtask

   function automatic logic [63:0] tp_val(input int i);
      return 64'hA5A5_0000_0000_0000 + 64'(i) * 64'h0001_0001;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, c1;
      logic anyv;
      int n0, n1, first0, first1, last0, last1;
      logic [63:0] got0 [16];
      logic [63:0] got1 [16];

      vecs[0]  = '{1'b1, 4'd5, 8'hFF, 64'h1122334455667788, 1'b0, 4'd0, 64'h0, 64'h0};
      vecs[1]  = '{1'b1, 4'd5, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0, 4'd0, 64'h0, 64'h0};
      vecs[2]  = '{1'b0, 4'd0, 8'h00, 64'h0, 1'b1, 4'd5, 64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA};
      vecs[3]  = '{1'b1, 4'd3, 8'hFF, 64'h1, 1'b0, 4'd0, 64'h0, 64'h0};
      vecs[4]  = '{1'b1, 4'd3, 8'hFF, 64'h2, 1'b1, 4'd3, 64'h1, 64'h2};
      vecs[5]  = '{1'b0, 4'd0, 8'h00, 64'h0, 1'b1, 4'd3, 64'h2, 64'h2};
      vecs[6]  = '{1'b1, 4'd7, 8'h81, 64'hDEADBEEFCAFEF00D, 1'b1, 4'd7, 64'h0, 64'hDE0000000000000D};
      vecs[7]  = '{1'b1, 4'd7, 8'h00, 64'hFFFFFFFFFFFFFFFF, 1'b0, 4'd0, 64'h0, 64'h0};
      vecs[8]  = '{1'b0, 4'd0, 8'h00, 64'h0, 1'b1, 4'd7, 64'hDE0000000000000D, 64'hDE0000000000000D};
      vecs[9]  = '{1'b1, 4'd9, 8'hFF, 64'h0123456789ABCDEF, 1'b1, 4'd5, 64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA};
      vecs[10] = '{1'b0, 4'd0, 8'h00, 64'h0, 1'b1, 4'd9, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF};

      // Reset state.
      idle_inputs();
      rst = 1'b1;
      repeat (3) tick();
      check("rst_vld0", 64'(rd_valid0), 64'h0);
      check("rst_vld1", 64'(rd_valid1), 64'h0);
      check("rst_init0", 64'(init_done0), 64'h0);
      check("rst_init1", 64'(init_done1), 64'h0);
      check("rst_dat0", rd_data0, 64'h0);
      check("rst_dat1", rd_data1, 64'h0);

      // Clear timing with accesses driven throughout CLEAR.
      rst = 1'b0;
      wr_en = 1'b1; wr_addr = 4'd0; wr_be = 8'hFF; wr_data = 64'hFFFFFFFFFFFFFFFF;
      rd_en = 1'b1; rd_addr = 4'd0;
      wait_ready(c0, c1, anyv);
      idle_inputs();
      repeat (3) begin
         tick();
         anyv = anyv | rd_valid0 | rd_valid1;
      end
      check("clear_cycles0", 64'(c0), 64'd16);
      check("clear_cycles1", 64'(c1), 64'd16);
      check("blocked_no_vld", 64'(anyv), 64'h0);

      // Every address reads zero after the fill.
      for (int i = 0; i < 16; i++) begin
         vec_t v;
         v = '{1'b0, 4'd0, 8'h00, 64'h0, 1'b1, 4'(i), 64'h0, 64'h0};
         apply_vec(v, $sformatf("clear_rd%0d", i));
      end

      // Byte enables, collisions, empty enables, independent ports.
      for (int i = 0; i < 11; i++) begin
         apply_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Pipelined writes 0..7 with a read of each address the next cycle.
      n0 = 0; n1 = 0; first0 = -1; first1 = -1; last0 = -1; last1 = -1;
      for (int t = 0; t < 14; t++) begin
         wr_en = (t < 8); wr_addr = 4'(t); wr_be = 8'hFF; wr_data = tp_val(t);
         rd_en = (t >= 1 && t <= 8); rd_addr = 4'(t - 1);
         tick();
         if (rd_valid0) begin
            if (first0 < 0) first0 = t;
            last0 = t;
            if (n0 < 16) got0[n0] = rd_data0;
            n0++;
         end
         if (rd_valid1) begin
            if (first1 < 0) first1 = t;
            last1 = t;
            if (n1 < 16) got1[n1] = rd_data1;
            n1++;
         end
      end
      idle_inputs();
      check("tp_first0", 64'(first0), 64'd3);
      check("tp_last0", 64'(last0), 64'd10);
      check("tp_count0", 64'(n0), 64'd8);
      check("tp_first1", 64'(first1), 64'd1);
      check("tp_last1", 64'(last1), 64'd8);
      check("tp_count1", 64'(n1), 64'd8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("tp_dat0_%0d", i), (i < n0) ? got0[i] : 64'hX, tp_val(i));
         check($sformatf("tp_dat1_%0d", i), (i < n1) ? got1[i] : 64'hX, tp_val(i));
      end

      // Reset at clear count 7 restarts the fill from zero.
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      repeat (7) tick();
      rst = 1'b1;
      tick();
      check("midclr_init0", 64'(init_done0), 64'h0);
      check("midclr_init1", 64'(init_done1), 64'h0);
      tick();
      rst = 1'b0;
      wait_ready(c0, c1, anyv);
      check("midclr_cycles0", 64'(c0), 64'd16);
      check("midclr_cycles1", 64'(c1), 64'd16);
      vecs[0] = '{1'b0, 4'd0, 8'h00, 64'h0, 1'b1, 4'd5, 64'h0, 64'h0};
      apply_vec(vecs[0], "midclr_zero");

      // Reset with two reads in flight discards them.
      apply_vec('{1'b1, 4'd1, 8'hFF, 64'h55, 1'b0, 4'd0, 64'h0, 64'h0}, "pre_wr");
      rd_en = 1'b1; rd_addr = 4'd1;
      tick();
      rd_addr = 4'd2;
      tick();
      rd_en = 1'b0;
      check("flight_dat1_pre", rd_data1, 64'h0);
      rst = 1'b1;
      tick();
      check("flight_rst_vld0", 64'(rd_valid0), 64'h0);
      check("flight_rst_vld1", 64'(rd_valid1), 64'h0);
      check("flight_rst_dat0", rd_data0, 64'h0);
      tick();
      rst = 1'b0;
      wait_ready(c0, c1, anyv);
      repeat (5) begin
         tick();
         anyv = anyv | rd_valid0 | rd_valid1;
      end
      check("flight_no_stale", 64'(anyv), 64'h0);
      check("flight_cycles0", 64'(c0), 64'd16);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_block_sdp.md
RAM_BLOCK_SDP -- requirements
Module: ram_block_sdp

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, which sets the word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, which sets the depth to 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter BYTE_WIDTH, default 8, which sets the lane width; DATA_WIDTH SHALL be an integer multiple of it; NB = DATA_WIDTH/BYTE_WIDTH.
REQ-004 The block SHALL have parameter READ_LATENCY, default 2, legal range 1..4, which sets the cycles from rd_en to rd_valid.
REQ-005 The block SHALL have parameter WRITE_FIRST, default 0, which selects the same-address collision mode (0 = old data, 1 = new data).
REQ-006 The block SHALL have parameter CLEAR_ON_RESET, default 1; when set to 1, the block zeroes the whole array after reset.
REQ-007 The block SHALL have port clk, input, width 1, the clock; all logic is on its rising edge.
REQ-008 The block SHALL have port rst, input, width 1, a synchronous, active-high reset.
REQ-009 The block SHALL have ports wr_en (input, 1), wr_addr (input, ADDR_WIDTH), wr_be (input, NB) and wr_data (input, DATA_WIDTH), which form the write port.
REQ-010 The block SHALL have ports rd_en (input, 1) and rd_addr (input, ADDR_WIDTH), which form the read request.
REQ-011 The block SHALL have ports rd_data (output, DATA_WIDTH) and rd_valid (output, 1), which form the read response.
REQ-012 The block SHALL have port init_done, output, width 1; it is high when the block accepts requests.

Function
REQ-013 The control FSM SHALL have two states: CLEAR and READY.
REQ-014 In CLEAR, a counter SHALL run from 0 to 2**ADDR_WIDTH-1 and write all-zero to one address per cycle.
REQ-015 The FSM SHALL enter READY in the cycle after the last clear write; init_done SHALL be 1 only in READY.
REQ-016 With CLEAR_ON_RESET=0, the FSM SHALL enter READY in the first cycle after rst deasserts, and memory contents SHALL be undefined.
REQ-017 In CLEAR, wr_en and rd_en SHALL be ignored: no write, no read, and rd_valid stays 0.
REQ-018 In READY with wr_en=1, only the byte lanes i with wr_be[i]=1 SHALL be updated at that edge, and the other lanes SHALL be retained.
REQ-019 A write with wr_be all-zero SHALL leave memory unchanged.
REQ-020 In READY, reads and writes SHALL be independent and may occur in the same cycle.
REQ-021 For rd_en=1 sampled at edge N, rd_data SHALL be valid and rd_valid=1 exactly at edge N+READ_LATENCY, for exactly one cycle per request.
REQ-022 Reads SHALL be fully pipelined: one request per cycle, no backpressure, and responses in request order.
REQ-023 When rd_valid=0, rd_data SHALL hold its last value.
REQ-024 For a same-cycle write and read to the same address: WRITE_FIRST=1 SHALL return the merged new word (written lanes new, others old); WRITE_FIRST=0 SHALL return the pre-write word.
REQ-025 A read issued the cycle after a write to the same address SHALL return the new data in both modes.
REQ-026 The address SHALL be used modulo 2**ADDR_WIDTH, with no out-of-range condition.

Reset
REQ-027 While rst=1: rd_data=0, rd_valid=0, init_done=0, the read pipeline SHALL be flushed, and the FSM SHALL be forced to CLEAR (or held pending READY when CLEAR_ON_RESET=0).
REQ-028 A reset asserted mid-clear SHALL restart the counter at 0.
REQ-029 A reset asserted with reads in flight SHALL discard them, with no rd_valid after rst deasserts.
REQ-030 Reset SHALL NOT alter memory contents except through the clear sequence.

Structure
REQ-031 The shared package ram_pkg SHALL hold the FSM state encoding (CLEAR, READY) and the READ_LATENCY bounds (min 1, max 4).
REQ-032 The block SHALL use one sub-module, ram_read_pipe: a parametrised data+valid delay line of READ_LATENCY-1 stages with synchronous reset.
REQ-033 The array SHALL be coded for inference as simple-dual-port block RAM with per-lane write enables.
REQ-034 Elaboration SHALL fail if READ_LATENCY is outside 1..4 or if DATA_WIDTH is not a multiple of BYTE_WIDTH.

Verification
REQ-035 Clear test (ADDR_WIDTH=4, CLEAR_ON_RESET=1): release rst -> init_done rises 16 cycles later; reads of all 16 addresses -> 0.
REQ-036 Byte-enable test: write 0x1122334455667788 to address 5, then write 0xAAAAAAAAAAAAAAAA with wr_be=0x0F -> a read of address 5 returns 0x11223344AAAAAAAA.
REQ-037 Collision test: memory holds 0x1 at address 3; same-cycle write 0x2, be=0xFF, plus read of address 3 -> WRITE_FIRST=0 returns 0x1, WRITE_FIRST=1 returns 0x2.
REQ-038 Latency/throughput test (READ_LATENCY=3): back-to-back reads of addresses 0..7 -> rd_valid is high for 8 consecutive cycles starting at edge N+3, with data in order.
REQ-039 Reset mid-operation test: assert rst at clear count 7, and separately with 2 reads in flight -> the clear restarts from 0 (full 16 cycles) and no stale rd_valid appears.
REQ-040 Blocked-access test: drive wr_en/rd_en during CLEAR -> rd_valid stays 0 and the addressed words read 0 after READY.
